// File: rtl/mor1kx_bus_arb_cpu.sv
// mor1kx_bus_arb_cpu
// Arbitrates the CPU instruction bus (ibus, read-only) and data bus (dbus)
// onto a single shared port toward one Wishbone bridge.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ibus_*_i / ibus_*_o      instruction requester and its response
//   dbus_*_i / dbus_*_o      data requester and its response
//   bus_*_o / bus_*_i        shared bridge request and response
//   grant_o                  current owner: 01 ibus, 10 dbus, 00 none
//
// A grant is held until the owner's access completes (single ack, last burst
// beat), errors, or the owner drops its request. Every release passes through
// one idle turnaround cycle before the next grant.
module mor1kx_bus_arb_cpu #(
  parameter int    OPTION_OPERAND_WIDTH = 32,
  parameter int    BURST_LENGTH         = 8,
  parameter string ARB_POLICY           = "ROUND_ROBIN"
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // instruction requester
  input  logic                            ibus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
  input  logic                            ibus_burst_i,
  output logic                            ibus_ack_o,
  output logic                            ibus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_o,
  // data requester
  input  logic                            dbus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  input  logic                            dbus_we_i,
  input  logic [3:0]                      dbus_bsel_i,
  input  logic                            dbus_burst_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
  // shared bridge port
  output logic                            bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_o,
  output logic                            bus_we_o,
  output logic [3:0]                      bus_bsel_o,
  output logic                            bus_burst_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
  output logic [1:0]                      grant_o
);

  localparam int CntW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BURST_LENGTH - 1);
  localparam bit DbusFirst = (ARB_POLICY == "DBUS_FIRST");

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic              r_last_d;   // 1: dbus won the most recent arbitration
  logic              w_last_d_d;
  logic              w_own_req;
  logic              w_own_burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_last_d <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_last_d <= w_last_d_d;
    end
  end

  // Owner mux: everything shared is a pure function of the current owner.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_burst = 1'b0;
    bus_adr_o   = '0;
    bus_dat_o   = '0;
    bus_we_o    = 1'b0;
    bus_bsel_o  = 4'h0;
    grant_o     = 2'b00;
    ibus_ack_o  = 1'b0;
    ibus_err_o  = 1'b0;
    dbus_ack_o  = 1'b0;
    dbus_err_o  = 1'b0;
    unique case (r_state)
      StGntI: begin
        w_own_req   = ibus_req_i;
        w_own_burst = ibus_burst_i;
        bus_adr_o   = ibus_adr_i;
        bus_bsel_o  = 4'hF;
        grant_o     = 2'b01;
        ibus_ack_o  = bus_ack_i;
        ibus_err_o  = bus_err_i;
      end
      StGntD: begin
        w_own_req   = dbus_req_i;
        w_own_burst = dbus_burst_i;
        bus_adr_o   = dbus_adr_i;
        bus_dat_o   = dbus_dat_i;
        bus_we_o    = dbus_we_i;
        bus_bsel_o  = dbus_bsel_i;
        grant_o     = 2'b10;
        dbus_ack_o  = bus_ack_i;
        dbus_err_o  = bus_err_i;
      end
      default: ;
    endcase
  end

  assign bus_req_o   = w_own_req;
  assign bus_burst_o = w_own_burst;
  assign ibus_dat_o  = bus_dat_i;
  assign dbus_dat_o  = bus_dat_i;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_last_d_d = r_last_d;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (ibus_req_i && dbus_req_i) begin
          // Round robin hands a tie to whoever did not win last time.
          if (DbusFirst || !r_last_d) begin
            w_state_d  = StGntD;
            w_last_d_d = 1'b1;
          end else begin
            w_state_d  = StGntI;
            w_last_d_d = 1'b0;
          end
        end else if (ibus_req_i) begin
          w_state_d  = StGntI;
          w_last_d_d = 1'b0;
        end else if (dbus_req_i) begin
          w_state_d  = StGntD;
          w_last_d_d = 1'b1;
        end
      end
      StGntI, StGntD: begin
        if (bus_err_i) begin
          w_state_d = StIdle;
        end else if (bus_ack_i) begin
          if (!w_own_burst || (r_cnt == CntLast)) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end else if (!w_own_req) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mor1kx_bus_arb_cpu.sv
// Randomized bench: two arbiters (round robin / burst 8, dbus first / burst 4)
// share one stimulus stream; each is compared every cycle to a
// transaction-level model of owner, beats delivered and last winner.
module tb_mor1kx_bus_arb_cpu;
  localparam int W = 32;
  localparam int NCyc = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         ibus_req_i, ibus_burst_i;
  logic [W-1:0] ibus_adr_i;
  logic         dbus_req_i, dbus_we_i, dbus_burst_i;
  logic [W-1:0] dbus_adr_i, dbus_dat_i;
  logic [3:0]   dbus_bsel_i;
  logic         bus_ack_i, bus_err_i;
  logic [W-1:0] bus_dat_i;

  logic         iack[2], ierr[2], dack[2], derr[2], breq[2], bwe[2], bburst[2];
  logic [W-1:0] idat[2], ddat[2], badr[2], bdat[2];
  logic [3:0]   bbsel[2];
  logic [1:0]   gnt[2];

  mor1kx_bus_arb_cpu #(
    .OPTION_OPERAND_WIDTH(W), .BURST_LENGTH(8), .ARB_POLICY("ROUND_ROBIN")
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
    .ibus_ack_o(iack[0]), .ibus_err_o(ierr[0]), .ibus_dat_o(idat[0]),
    .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
    .dbus_we_i(dbus_we_i), .dbus_bsel_i(dbus_bsel_i), .dbus_burst_i(dbus_burst_i),
    .dbus_ack_o(dack[0]), .dbus_err_o(derr[0]), .dbus_dat_o(ddat[0]),
    .bus_req_o(breq[0]), .bus_adr_o(badr[0]), .bus_dat_o(bdat[0]), .bus_we_o(bwe[0]),
    .bus_bsel_o(bbsel[0]), .bus_burst_o(bburst[0]),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i),
    .grant_o(gnt[0])
  );

  mor1kx_bus_arb_cpu #(
    .OPTION_OPERAND_WIDTH(W), .BURST_LENGTH(4), .ARB_POLICY("DBUS_FIRST")
  ) u_df (
    .clk(clk), .rst_n(rst_n),
    .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
    .ibus_ack_o(iack[1]), .ibus_err_o(ierr[1]), .ibus_dat_o(idat[1]),
    .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
    .dbus_we_i(dbus_we_i), .dbus_bsel_i(dbus_bsel_i), .dbus_burst_i(dbus_burst_i),
    .dbus_ack_o(dack[1]), .dbus_err_o(derr[1]), .dbus_dat_o(ddat[1]),
    .bus_req_o(breq[1]), .bus_adr_o(badr[1]), .bus_dat_o(bdat[1]), .bus_we_o(bwe[1]),
    .bus_bsel_o(bbsel[1]), .bus_burst_o(bburst[1]),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i),
    .grant_o(gnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: owner 0 none, 1 ibus, 2 dbus; beats = acks delivered.
  int owner[2];
  int beats[2];
  bit last_was_d[2];
  int burst_len[2] = '{8, 4};
  bit dbus_first[2] = '{1'b0, 1'b1};
  bit active[2];   // requester 0 ibus, 1 dbus has an outstanding access

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0;
      beats[k] = 0;
      last_was_d[k] = 1'b1;
    end
  endtask

  task automatic model_step(input int k);
    int  o;
    int  win;
    bit  rq;
    bit  bu;
    o = owner[k];
    if (o == 0) begin
      win = 0;
      if (ibus_req_i && dbus_req_i) win = dbus_first[k] ? 2 : (last_was_d[k] ? 1 : 2);
      else if (ibus_req_i) win = 1;
      else if (dbus_req_i) win = 2;
      if (win != 0) begin
        owner[k] = win;
        beats[k] = 0;
        last_was_d[k] = (win == 2);
      end
    end else begin
      rq = (o == 1) ? ibus_req_i : dbus_req_i;
      bu = (o == 1) ? ibus_burst_i : dbus_burst_i;
      if (bus_err_i) begin
        owner[k] = 0;
        if (k == 0) active[o-1] = 1'b0;
      end else if (bus_ack_i) begin
        beats[k]++;
        if (!bu || beats[k] == burst_len[k]) begin
          owner[k] = 0;
          if (k == 0) active[o-1] = 1'b0;
        end
      end else if (!rq) begin
        owner[k] = 0;
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic [12:0]  ctl;
    logic [W-1:0] adr;
    logic [W-1:0] dat;
    logic [12:0]  ectl;
    logic [W-1:0] eadr;
    logic [W-1:0] edat;
    ctl = {gnt[k], breq[k], bwe[k], bbsel[k], bburst[k], iack[k], ierr[k], dack[k], derr[k]};
    adr = badr[k];
    dat = bdat[k];
    ectl = '0;
    eadr = '0;
    edat = '0;
    if (owner[k] == 1) begin
      ectl = {2'b01, ibus_req_i, 1'b0, 4'hF, ibus_burst_i, bus_ack_i, bus_err_i, 2'b00};
      eadr = ibus_adr_i;
    end else if (owner[k] == 2) begin
      ectl = {2'b10, dbus_req_i, dbus_we_i, dbus_bsel_i, dbus_burst_i, 2'b00,
              bus_ack_i, bus_err_i};
      eadr = dbus_adr_i;
      edat = dbus_dat_i;
    end
    check_eq($sformatf("ctl%0d", k), 64'(ctl), 64'(ectl));
    check_eq($sformatf("adr%0d", k), 64'(adr), 64'(eadr));
    check_eq($sformatf("bdat%0d", k), 64'(dat), 64'(edat));
    check_eq($sformatf("rdat%0d", k), {idat[k], ddat[k]}, {bus_dat_i, bus_dat_i});
  endtask

  task automatic drive_random();
    if (!active[0] && $urandom_range(0, 9) < 3) begin
      active[0] = 1'b1;
      ibus_adr_i = $urandom;
      ibus_burst_i = $urandom_range(0, 1) == 1;
    end else if (active[0] && $urandom_range(0, 59) == 0) begin
      active[0] = 1'b0;
    end
    if (!active[1] && $urandom_range(0, 9) < 3) begin
      active[1] = 1'b1;
      dbus_adr_i = $urandom;
      dbus_dat_i = $urandom;
      dbus_we_i = $urandom_range(0, 1) == 1;
      dbus_bsel_i = 4'($urandom_range(0, 15));
      dbus_burst_i = $urandom_range(0, 1) == 1;
    end else if (active[1] && $urandom_range(0, 59) == 0) begin
      active[1] = 1'b0;
    end
    ibus_req_i = active[0];
    dbus_req_i = active[1];
    bus_ack_i = $urandom_range(0, 9) < 4;
    bus_err_i = $urandom_range(0, 29) == 0;
    bus_dat_i = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    ibus_req_i = 1'b0; ibus_adr_i = '0; ibus_burst_i = 1'b0;
    dbus_req_i = 1'b0; dbus_adr_i = '0; dbus_dat_i = '0; dbus_we_i = 1'b0;
    dbus_bsel_i = 4'h0; dbus_burst_i = 1'b0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_dat_i = 32'h1234_5678;
    active[0] = 1'b0;
    active[1] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst_n = 1'b1;

    for (int c = 0; c < NCyc; c++) begin
      @(negedge clk);
      // Occasional asynchronous reset, frequently landing mid-burst.
      rst_n = ($urandom_range(0, 149) != 0);
      drive_random();
      #1;
      if (!rst_n) model_reset();
      check_inst(0);
      check_inst(1);
      @(posedge clk);
      #0;
      if (rst_n) begin
        model_step(0);
        model_step(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_bus_arb_cpu.md
MOR1KX_BUS_ARB_CPU -- requirements
Module: mor1kx_bus_arb_cpu

Interface
REQ-001 Parameter: OPTION_OPERAND_WIDTH, 32, data and address width.
REQ-002 Parameter: BURST_LENGTH, 8, number of acks per burst; legal values 1, 4, 8.
REQ-003 Parameter: ARB_POLICY, "ROUND_ROBIN", grant policy; "ROUND_ROBIN" or "DBUS_FIRST".
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 Ports: ibus_req_i  in  1, ibus_adr_i  in  W, ibus_burst_i  in  1; instruction requester, read-only.
REQ-007 Ports: ibus_ack_o  out  1, ibus_err_o  out  1, ibus_dat_o  out  W; instruction response.
REQ-008 Ports: dbus_req_i  in  1, dbus_adr_i  in  W, dbus_dat_i  in  W, dbus_we_i  in  1, dbus_bsel_i  in  4, dbus_burst_i  in  1; data requester.
REQ-009 Ports: dbus_ack_o  out  1, dbus_err_o  out  1, dbus_dat_o  out  W; data response.
REQ-010 Ports: bus_req_o  out  1, bus_adr_o  out  W, bus_dat_o  out  W, bus_we_o  out  1, bus_bsel_o  out  4, bus_burst_o  out  1; shared port toward one mor1kx_bus_if_wb32 bridge.
REQ-011 Ports: bus_ack_i  in  1, bus_err_i  in  1, bus_dat_i  in  W; bridge response.
REQ-012 Port: grant_o  out  2  current owner, 2'b01 ibus, 2'b10 dbus, 2'b00 none.

Function
REQ-013 FSM states: IDLE, GNT_I, GNT_D; state, burst counter and last-winner flag are registers.
REQ-014 IDLE: a pending request moves to GNT_I or GNT_D at the next edge; no request keeps IDLE.
REQ-015 Both requests in IDLE under ROUND_ROBIN: grant the port that did not win last; last-winner resets to dbus, so ibus wins the first tie.
REQ-016 Both requests in IDLE under DBUS_FIRST: dbus always wins.
REQ-017 Shared outputs combinationally mux the owner's signals: in GNT_I, bus_we_o=0, bus_bsel_o=4'hF, bus_dat_o=0; in GNT_D, all dbus fields pass through.
REQ-018 bus_req_o = owner's req in GNT_I/GNT_D, 0 in IDLE; bus_burst_o = owner's burst, 0 in IDLE.
REQ-019 Latency: request seen in IDLE at edge N -> bus_req_o high in cycle N+1.
REQ-020 bus_ack_i/bus_err_i route only to the owner's ack/err; the non-owner's ack/err are 0; ibus_dat_o and dbus_dat_o both equal bus_dat_i.
REQ-021 Burst counter: width clog2(BURST_LENGTH), minimum 1; cleared on grant; increments on each bus_ack_i while owner burst=1.
REQ-022 Release to IDLE on bus_ack_i with owner burst=0 (single access).
REQ-023 Release to IDLE on bus_ack_i with owner burst=1 and counter=BURST_LENGTH-1.
REQ-024 Release to IDLE on bus_err_i at any point, including mid-burst; remaining burst beats are abandoned.
REQ-025 Release to IDLE if the owner drops req with no ack/err in that cycle (aborted request).
REQ-026 Each release returns to IDLE for exactly one cycle (turnaround), so back-to-back grants are separated by one cycle with bus_req_o=0.
REQ-027 The non-owner's request is held pending, never dropped; the arbiter does not preempt an active grant.
REQ-028 Simultaneous ack and err: err wins; owner sees ack=1 and err=1 as given, and the FSM releases.
REQ-029 Last-winner updates on every grant.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, counter=0, last-winner=dbus, grant_o=0, and bus_req_o, bus_burst_o, bus_we_o, ibus_ack_o, ibus_err_o, dbus_ack_o, dbus_err_o low.
REQ-031 Reset mid-burst aborts the grant with no further acks forwarded; first grant after release needs rst_n high plus one edge.

Verification
REQ-032 Single ibus read: ibus_req_i=1, adr=0x100, bridge acks 2 cycles later -> grant_o=01 one cycle after req, one ibus_ack_o, grant_o=00 next cycle.
REQ-033 Tie after reset, ROUND_ROBIN, both single requests held -> ibus served first, one turnaround cycle, then dbus; dbus_we/bsel=4'h3/dat=0xDEADBEEF appear on bus.
REQ-034 ibus burst, BURST_LENGTH=8, dbus_req_i raised at beat 3 -> 8 acks to ibus only, dbus_ack_o stays 0, dbus granted after the turnaround cycle.
REQ-035 bus_err_i on beat 5 of a dbus burst -> dbus_err_o=1 for that cycle, IDLE next cycle, pending ibus granted the cycle after.
REQ-036 DBUS_FIRST with both requesting continuously -> dbus wins every arbitration; ibus granted only when dbus_req_i=0 in IDLE.
REQ-037 rst_n low mid-burst at beat 2 -> all outputs 0 immediately, grant_o=00; new request after rst_n high is granted normally.
